rom_load_seq: RTL and testbench

Parametrised read sequencer between the load path and the instruction/constant ROM. It fetches the bytes of an LB/LH/LW/LBU/LHU access through a ROM port of configurable width and read latency. It reassembles the little-endian bytes, handles addresses that span ROM words, and returns one sign- or zero-extended 32-bit result per request over a ready/valid handshake. It replaces the fixed byte-serial, fixed-latency rodata sequencer in the memory stage.

---
 rtl/rom_load_seq.sv | 207 ++++++++++++++++++++
 tb/tb_rom_load_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_seq.sv
// rom_load_seq: load sequencer between the memory-stage load path and the
// instruction/constant ROM. One request (LB/LH/LW/LBU/LHU) is fetched as
// B ROM beats through a port of ROM_DW bits with RD_LAT cycles of read
// latency. The returned bytes are reassembled little-endian, and one
// sign/zero-extended 32-bit result is returned.
//
// Handshake: a request is taken in a cycle where req=1 and req_ready=1.
// req_ready is high only in IDLE, and nothing is queued while busy. Each
// request produces exactly one rd_valid pulse, carrying rd_data and err.
// There is no back-pressure on the result.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req, mem_op, addr  load request (mem_op: 000 LB, 001 LH, 010 LW,
//                      100 LBU, 101 LHU; anything else is an error)
//   req_ready          high only in IDLE
//   rom_en, rom_addr   ROM read strobe and word address (addr 0 when idle)
//   rom_data           ROM read data, valid RD_LAT cycles after rom_en
//   rd_valid, rd_data  one-cycle result strobe and result (0 when idle)
//   err                illegal op or rejected misaligned access
//   dbg_state          current FSM state, for observation only
module rom_load_seq #(
  parameter int ROM_DW      = 8,
  parameter int ROM_AW      = 16,
  parameter int RD_LAT      = 1,
  parameter int MISALIGN_OK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        mem_op,
  input  logic [31:0]       addr,
  output logic              req_ready,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_data,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int BPW    = ROM_DW / 8;
  localparam int OFFW   = $clog2(BPW);
  // A misaligned access can touch one more ROM word than an aligned one.
  localparam int NWORDS = (MISALIGN_OK != 0) ? (4 / BPW + 1) : (4 / BPW);
  localparam int BUFW   = ROM_DW * NWORDS;
  localparam int NBYTES = BUFW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic                sgn_q;
  logic [2:0]          off_q;
  logic [2:0]          n_q;
  logic [3:0]          b_q;
  logic [2:0]          beat_q;
  logic [2:0]          cnt_q;
  logic [BUFW-1:0]     buf_q;
  logic [BUFW-1:0]     buf_next;
  logic [RD_LAT-1:0]   vld_dl;
  logic [2:0]          idx_dl [RD_LAT];
  logic [31:0]         result;

  // Request decode
  logic              op_legal;
  logic              mis_in;
  logic [2:0]        n_in;
  logic [2:0]        off_in;
  logic [3:0]        b_in;
  logic [ROM_AW-1:0] w_in;

  always_comb begin
    op_legal = (mem_op == 3'b000) || (mem_op == 3'b001) || (mem_op == 3'b010) ||
               (mem_op == 3'b100) || (mem_op == 3'b101);
    case (mem_op[1:0])
      2'b00:   n_in = 3'd1;
      2'b01:   n_in = 3'd2;
      default: n_in = 3'd4;
    endcase
    off_in = addr[2:0] & 3'(BPW - 1);
    // ceil((off + N) / BPW)
    b_in   = (4'(off_in) + 4'(n_in) + 4'(BPW - 1)) >> OFFW;
    mis_in = ((n_in == 3'd2) && addr[0]) || ((n_in == 3'd4) && (addr[1:0] != 2'b00));
    w_in   = addr[ROM_AW+OFFW-1:OFFW];
  end

  logic unused_addr;
  assign unused_addr = &{1'b0, addr};

  // Returning beat lands in its slot of the reassembly buffer. The result
  // register reads buf_next so the last beat is usable in its capture cycle.
  always_comb begin
    buf_next = buf_q;
    for (int w = 0; w < NWORDS; w++) begin
      if (vld_dl[RD_LAT-1] && (idx_dl[RD_LAT-1] == 3'(w))) begin
        buf_next[w*ROM_DW +: ROM_DW] = rom_data;
      end
    end
  end

  logic [7:0] byte_v [4];
  logic       fill;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_v[i] = 8'h00;
      for (int j = 0; j < NBYTES; j++) begin
        if (4'(j) == (4'(off_q) + 4'(i))) byte_v[i] = buf_next[j*8 +: 8];
      end
    end
    fill = sgn_q && ((n_q == 3'd1) ? byte_v[0][7] : byte_v[1][7]);
    case (n_q)
      3'd1:    result = {{24{fill}}, byte_v[0]};
      3'd2:    result = {{16{fill}}, byte_v[1], byte_v[0]};
      default: result = {byte_v[3], byte_v[2], byte_v[1], byte_v[0]};
    endcase
  end

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sgn_q    <= 1'b0;
      off_q    <= 3'd0;
      n_q      <= 3'd0;
      b_q      <= 4'd0;
      beat_q   <= 3'd0;
      cnt_q    <= 3'd0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      rd_valid <= 1'b0;
      rd_data  <= 32'h0;
      err      <= 1'b0;
      buf_q    <= '0;
      vld_dl   <= '0;
      for (int j = 0; j < RD_LAT; j++) idx_dl[j] <= 3'd0;
    end else begin
      // Beat tag delay line: stage RD_LAT-1 marks the cycle its data is valid.
      vld_dl[0] <= rom_en;
      idx_dl[0] <= beat_q;
      for (int j = 1; j < RD_LAT; j++) begin
        vld_dl[j] <= vld_dl[j-1];
        idx_dl[j] <= idx_dl[j-1];
      end
      buf_q <= buf_next;

      case (state)
        IDLE: begin
          if (req) begin
            sgn_q <= ~mem_op[2];
            off_q <= off_in;
            n_q   <= n_in;
            b_q   <= b_in;
            if (!op_legal || ((MISALIGN_OK == 0) && mis_in)) begin
              state    <= DONE;
              rd_valid <= 1'b1;
              rd_data  <= 32'h0;
              err      <= 1'b1;
            end else begin
              state    <= ISSUE;
              rom_en   <= 1'b1;
              rom_addr <= w_in;
              beat_q   <= 3'd0;
            end
          end
        end
        ISSUE: begin
          if (4'(beat_q) == (b_q - 4'd1)) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
            cnt_q    <= 3'd0;
            state    <= DRAIN;
          end else begin
            beat_q   <= beat_q + 3'd1;
            rom_addr <= rom_addr + ROM_AW'(1); // wraps silently at the top
          end
        end
        DRAIN: begin
          // Waits for the last beat; its data is captured in the final cycle.
          if (cnt_q == 3'(RD_LAT - 1)) begin
            state    <= DONE;
            rd_valid <= 1'b1;
            rd_data  <= result;
            err      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin // DONE
          rd_valid <= 1'b0;
          rd_data  <= 32'h0;
          err      <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_seq.sv
// Testbench for rom_load_seq. Four instances cover different ROM widths,
// latencies and misalignment policies, each with its own latency-accurate
// ROM model. Results are predicted by a byte-level load model and compared
// through a tagged expected queue.
module tb_rom_load_seq;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        req_a   [4];
  logic [2:0]  op_a    [4];
  logic [31:0] addr_a  [4];
  logic        rdy_a   [4];
  logic        en_a    [4];
  logic [15:0] raddr_a [4];
  logic [31:0] rdat_a  [4];
  logic        vld_a   [4];
  logic [31:0] data_a  [4];
  logic        err_a   [4];
  logic [1:0]  st_a    [4];

  function automatic int dw_of(input int i);
    case (i)
      0: return 8;
      1: return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      2: return 2;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit mok_of(input int i);
    return (i != 2);
  endfunction

  rom_load_seq #(.ROM_DW(8), .ROM_AW(16), .RD_LAT(1), .MISALIGN_OK(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req_a[0]), .mem_op(op_a[0]), .addr(addr_a[0]),
    .req_ready(rdy_a[0]), .rom_en(en_a[0]), .rom_addr(raddr_a[0]), .rom_data(rdat_a[0][7:0]),
    .rd_valid(vld_a[0]), .rd_data(data_a[0]), .err(err_a[0]), .dbg_state(st_a[0]));

  rom_load_seq #(.ROM_DW(32), .ROM_AW(16), .RD_LAT(1), .MISALIGN_OK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req_a[1]), .mem_op(op_a[1]), .addr(addr_a[1]),
    .req_ready(rdy_a[1]), .rom_en(en_a[1]), .rom_addr(raddr_a[1]), .rom_data(rdat_a[1]),
    .rd_valid(vld_a[1]), .rd_data(data_a[1]), .err(err_a[1]), .dbg_state(st_a[1]));

  rom_load_seq #(.ROM_DW(16), .ROM_AW(16), .RD_LAT(2), .MISALIGN_OK(0)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req_a[2]), .mem_op(op_a[2]), .addr(addr_a[2]),
    .req_ready(rdy_a[2]), .rom_en(en_a[2]), .rom_addr(raddr_a[2]), .rom_data(rdat_a[2][15:0]),
    .rd_valid(vld_a[2]), .rd_data(data_a[2]), .err(err_a[2]), .dbg_state(st_a[2]));

  rom_load_seq #(.ROM_DW(16), .ROM_AW(16), .RD_LAT(3), .MISALIGN_OK(1)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req_a[3]), .mem_op(op_a[3]), .addr(addr_a[3]),
    .req_ready(rdy_a[3]), .rom_en(en_a[3]), .rom_addr(raddr_a[3]), .rom_data(rdat_a[3][15:0]),
    .rd_valid(vld_a[3]), .rd_data(data_a[3]), .err(err_a[3]), .dbg_state(st_a[3]));

  // ROM contents: test-plan bytes at 0x100..0x107, address hash elsewhere.
  function automatic logic [7:0] rom_byte(input logic [31:0] ba);
    case (ba)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h83;
      32'h103: return 8'hF4;
      32'h104: return 8'h55;
      32'h105: return 8'h66;
      32'h106: return 8'h77;
      32'h107: return 8'h88;
      default: return ba[7:0] ^ ba[15:8] ^ 8'h3C ^ {6'b0, ba[17:16]};
    endcase
  endfunction

  function automatic logic [31:0] rom_word(input int i, input logic [15:0] wa);
    logic [31:0] w;
    int bpw;
    w = 32'h0;
    bpw = dw_of(i) / 8;
    for (int b = 0; b < bpw; b++) w[b*8 +: 8] = rom_byte(32'(wa) * 32'(bpw) + 32'(b));
    return w;
  endfunction

  // ROM models: address/enable pipeline, data valid RD_LAT cycles after rom_en.
  logic [15:0] ap [4][4];
  logic        ep [4][4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      ap[i][0] <= raddr_a[i];
      ep[i][0] <= en_a[i];
      for (int j = 1; j < 4; j++) begin
        ap[i][j] <= ap[i][j-1];
        ep[i][j] <= ep[i][j-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdat_a[i] = ep[i][lat_of(i)-1] ? rom_word(i, ap[i][lat_of(i)-1]) : 32'hA5A5A5A5;
    end
  end

  // Reference load: {err, data}
  function automatic logic [32:0] ref_load(input int i, input logic [2:0] op, input logic [31:0] a);
    int bpw, n;
    logic [31:0] mask, v;
    bit legal, sgn, fillb;
    bpw = dw_of(i) / 8;
    mask = (32'h1 << (16 + $clog2(bpw))) - 32'h1;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    n = (op[1:0] == 2'd0) ? 1 : ((op[1:0] == 2'd1) ? 2 : 4);
    if (!legal || (!mok_of(i) && ((a % n) != 0))) return {1'b1, 32'h0};
    v = 32'h0;
    for (int k = 0; k < n; k++) v[k*8 +: 8] = rom_byte((a + 32'(k)) & mask);
    sgn = !op[2];
    fillb = sgn && v[8*n-1];
    for (int k = 8 * n; k < 32; k++) v[k] = fillb;
    return {1'b0, v};
  endfunction

  function automatic int ref_beats(input int i, input logic [2:0] op, input logic [31:0] a);
    int bpw, n;
    logic [32:0] r;
    r = ref_load(i, op, a);
    if (r[32]) return 0;
    bpw = dw_of(i) / 8;
    n = (op[1:0] == 2'd0) ? 1 : ((op[1:0] == 2'd1) ? 2 : 4);
    return (int'(a % bpw) + n + bpw - 1) / bpw;
  endfunction

  function automatic int ref_lat(input int i, input logic [2:0] op, input logic [31:0] a);
    if (ref_load(i, op, a) >= 33'h1_0000_0000) return 1;
    return ref_beats(i, op, a) + lat_of(i) + 1;
  endfunction

  // Scoreboard: {inst[1:0], err, data}
  logic [34:0] exp_q[$];
  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld_a[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_rd_valid: inst %0d got data=%0h err=%0b expected no result",
                   i, data_a[i], err_a[i]);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check($sformatf("result_inst%0d", i), {29'h0, 2'(i), err_a[i], data_a[i]},
                {29'h0, e});
        end
      end else if ((data_a[i] !== 32'h0) || (err_a[i] !== 1'b0)) begin
        n_miss++;
        $display("FAIL idle_outputs: inst %0d got data=%0h err=%0b expected 0", i, data_a[i], err_a[i]);
      end
    end
  end

  // One request: drive, watch beats cycle by cycle, check latency/ready.
  task automatic do_req(input int i, input logic [2:0] op, input logic [31:0] a,
                        input logic [32:0] exp, input int lat, input bit poke);
    int nb, bpw, got_c;
    bit seen, beat_bad, busy_bad, exp_en;
    logic [31:0] mask;
    logic [15:0] w, exp_ad;
    bpw = dw_of(i) / 8;
    mask = (32'h1 << (16 + $clog2(bpw))) - 32'h1;
    w = 16'((a & mask) / bpw);
    nb = ref_beats(i, op, a);
    seen = 0; beat_bad = 0; busy_bad = 0; got_c = 0;
    @(negedge clk);
    req_a[i] = 1'b1; op_a[i] = op; addr_a[i] = a;
    check("ready_at_accept", 64'(rdy_a[i]), 64'd1);
    @(posedge clk);
    exp_q.push_back({2'(i), exp});
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (poke && (c < lat)) begin
        req_a[i] = 1'b1;
        addr_a[i] = $urandom_range(0, 1023);
        if (rdy_a[i] !== 1'b0) busy_bad = 1;
      end else begin
        req_a[i] = 1'b0;
      end
      exp_en = (c <= nb);
      exp_ad = exp_en ? 16'(w + 16'(c - 1)) : 16'h0;
      if ((en_a[i] !== exp_en) || (raddr_a[i] !== exp_ad)) beat_bad = 1;
      if (vld_a[i] === 1'b1) begin
        seen = 1; got_c = c;
        break;
      end
    end
    req_a[i] = 1'b0;
    check("latency", 64'(seen ? got_c : 0), 64'(lat));
    check("rom_beats_ok", 64'(beat_bad), 64'd0);
    if (poke) check("busy_ready_low", 64'(busy_bad), 64'd0);
    @(negedge clk);
    check("ready_after_done", {62'h0, rdy_a[i], vld_a[i]}, 64'b10);
  endtask

  typedef struct {
    int          inst;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [32:0] exp;
    int          lat;
    bit          poke;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0;
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 1'b0; op_a[i] = 3'd0; addr_a[i] = 32'h0;
    end

    tbl[0]  = '{0, 3'b010, 32'h100,   {1'b0, 32'hF4832211}, 6, 0};
    tbl[1]  = '{0, 3'b000, 32'h102,   {1'b0, 32'hFFFFFF83}, 3, 0};
    tbl[2]  = '{0, 3'b100, 32'h102,   {1'b0, 32'h00000083}, 3, 0};
    tbl[3]  = '{0, 3'b001, 32'h102,   {1'b0, 32'hFFFFF483}, 4, 0};
    tbl[4]  = '{0, 3'b101, 32'h102,   {1'b0, 32'h0000F483}, 4, 0};
    tbl[5]  = '{1, 3'b010, 32'h102,   {1'b0, 32'h6655F483}, 4, 0};
    tbl[6]  = '{2, 3'b001, 32'h101,   {1'b1, 32'h00000000}, 1, 0};
    tbl[7]  = '{2, 3'b011, 32'h100,   {1'b1, 32'h00000000}, 1, 0};
    tbl[8]  = '{2, 3'b010, 32'h104,   {1'b0, 32'h88776655}, 5, 0};
    tbl[9]  = '{3, 3'b010, 32'h104,   {1'b0, 32'h88776655}, 6, 1};
    tbl[10] = '{3, 3'b001, 32'h103,   {1'b0, 32'h000055F4}, 6, 0};
    tbl[11] = '{1, 3'b000, 32'h107,   {1'b0, 32'hFFFFFF88}, 3, 0};
    tbl[12] = '{0, 3'b111, 32'h100,   {1'b1, 32'h00000000}, 1, 0};
    tbl[13] = '{2, 3'b010, 32'h102,   {1'b1, 32'h00000000}, 1, 0};
    tbl[14] = '{1, 3'b101, 32'h103,   {1'b0, 32'h000055F4}, 4, 0};
    tbl[15] = '{0, 3'b010, 32'hFFFE,  {1'b0, 32'h3D3C3C3D}, 6, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_state_inst%0d", i),
            {rdy_a[i], en_a[i], raddr_a[i], vld_a[i], data_a[i], err_a[i]},
            {1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0});
    end
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      do_req(tbl[v].inst, tbl[v].op, tbl[v].addr, tbl[v].exp, tbl[v].lat, tbl[v].poke);
    end

    // Random requests, including illegal ops and addresses at the ROM top.
    for (int r = 0; r < 40; r++) begin
      int i;
      logic [2:0] op;
      logic [31:0] a, mask;
      i = $urandom_range(0, 3);
      op = 3'($urandom_range(0, 7));
      mask = (32'h1 << (16 + $clog2(dw_of(i) / 8))) - 32'h1;
      if ($urandom_range(0, 3) == 0) a = mask - 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 1023));
      do_req(i, op, a, ref_load(i, op, a), ref_lat(i, op, a), $urandom_range(0, 1) == 1);
    end

    // Reset in cycle 2 of an LW: outputs clear, in-flight beats discarded.
    @(negedge clk);
    req_a[0] = 1'b1; op_a[0] = 3'b010; addr_a[0] = 32'h100;
    @(negedge clk);
    req_a[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_midop_outputs",
          {rdy_a[0], en_a[0], raddr_a[0], vld_a[0], data_a[0], err_a[0]},
          {1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0});
    rst_n = 1'b1;
    begin
      bit any_vld;
      any_vld = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (vld_a[0] === 1'b1) any_vld = 1;
      end
      check("no_rd_valid_after_reset", 64'(any_vld), 64'd0);
    end

    // Request works normally after the aborted one.
    do_req(0, 3'b010, 32'h104, {1'b0, 32'h88776655}, 6, 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
